// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline controller.
// FSM state enum, CP0 cause codes and the default exception vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_SYS  = 5'd8;
  localparam logic [4:0] CAUSE_BP   = 5'd9;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline <-> controller bundle (stall, exception,
// interrupt, redirect, status and perf signals). master = pipeline, slave = ctrl.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int INT_W  = 6,
  parameter int PC_W   = 32
);
  logic [STAGES-1:0] stallreq;
  logic [STAGES-1:0] stall;
  logic              excp_valid;
  logic [4:0]        excp_code;
  logic [PC_W-1:0]   excp_pc;
  logic              eret_valid;
  logic [INT_W-1:0]  int_i;
  logic [INT_W-1:0]  int_mask;
  logic              int_en;
  logic [INT_W-1:0]  int_ack;
  logic              flush;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   epc;
  logic [4:0]        cause;
  logic [INT_W-1:0]  int_pending;
  logic              stall_timeout;
  logic [31:0]       perf_stall_cyc;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output stallreq, excp_valid, excp_code, excp_pc, eret_valid,
    output int_i, int_mask, int_en, int_ack,
    input  stall, flush, redirect_valid, redirect_pc, epc, cause,
    input  int_pending, stall_timeout, perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  stallreq, excp_valid, excp_code, excp_pc, eret_valid,
    input  int_i, int_mask, int_en, int_ack,
    output stall, flush, redirect_valid, redirect_pc, epc, cause,
    output int_pending, stall_timeout, perf_stall_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sync.sv
// pipe_ctrl_sync: W-wide 2-flop synchroniser, sync active-high reset.
// Ports: clk, rst, d_i (async in), q_o (synchronised out).
module pipe_ctrl_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception/eret/interrupt flush-redirect FSM,
// EPC/cause, interrupt pending, stall watchdog. Ports: clk, rst, bus (slave).
// PIPE_CTRL_PERF_EN enables perf_stall_cyc / perf_flush_cnt counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              STAGES    = 6,
  parameter int              INT_W     = 6,
  parameter int              PC_W      = 32,
  parameter int              FLUSH_CYC = 1,
  parameter int              TMO_W     = 8,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF)
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0]    FCNT_INIT = FW'(FLUSH_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};

  // Highest requesting stage holds itself and everything older.
  function automatic logic [STAGES-1:0] therm(input logic [STAGES-1:0] req);
    logic [STAGES-1:0] res;
    logic              acc;
    acc = 1'b0;
    res = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | req[i];
      res[i] = acc;
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [4:0]        cause_q, cause_d;
  logic [INT_W-1:0]  pend_q, pend_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic              to_q, to_d;
  logic [INT_W-1:0]  int_sync;
  logic [STAGES-1:0] stall_s;
  logic              flush_s;
  logic              rv_s;
  logic              accept;
  logic              int_req;

  pipe_ctrl_sync #(.W(INT_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.int_i),
    .q_o (int_sync)
  );

  // Sync level sets; ack clears; set wins over ack.
  assign pend_d  = (pend_q & ~bus.int_ack) | int_sync;
  assign int_req = bus.int_en && |(pend_q & bus.int_mask);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tgt_d   = tgt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    flush_s = 1'b0;
    rv_s    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.excp_valid) begin
          accept  = 1'b1;
          epc_d   = bus.excp_pc;
          cause_d = bus.excp_code;
          tgt_d   = EXC_VEC;
        end else if (bus.eret_valid) begin
          accept = 1'b1;
          tgt_d  = epc_q;
        end else if (int_req) begin
          accept  = 1'b1;
          epc_d   = bus.excp_pc;
          cause_d = CAUSE_INT;
          tgt_d   = EXC_VEC;
        end
        if (accept) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_INIT;
        end
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        if (fcnt_q == '0) state_d = ST_REDIRECT;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      ST_REDIRECT: begin
        rv_s    = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_s = flush_s ? '0 : therm(bus.stallreq);

  always_comb begin
    wd_d = '0;
    if (stall_s != '0) begin
      wd_d = (wd_q == TMO_MAX) ? wd_q : wd_q + 1'b1;
    end
    to_d = to_q | (wd_d == TMO_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      tgt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      pend_q  <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tgt_q   <= tgt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign bus.stall          = stall_s;
  assign bus.flush          = flush_s;
  assign bus.redirect_valid = rv_s;
  assign bus.redirect_pc    = rv_s ? tgt_q : '0;
  assign bus.epc            = epc_q;
  assign bus.cause          = cause_q;
  assign bus.int_pending    = pend_q;
  assign bus.stall_timeout  = to_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall_q;
  logic [31:0] pflush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      if (stall_s != '0) pstall_q <= pstall_q + 32'd1;
      if (accept)        pflush_q <= pflush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cyc = pstall_q;
  assign bus.perf_flush_cnt = pflush_q;
`else
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Built with TMO_W=4 so the watchdog trips in 15 stalled cycles.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic ok;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(6), .INT_W(6), .PC_W(32)) bus ();

  pipe_ctrl #(.TMO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stallreq   = '0;
    bus.excp_valid = 1'b0;
    bus.excp_code  = '0;
    bus.excp_pc    = '0;
    bus.eret_valid = 1'b0;
    bus.int_i      = '0;
    bus.int_mask   = '0;
    bus.int_en     = 1'b0;
    bus.int_ack    = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall", bus.stall, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_rv", bus.redirect_valid, 0);
    check("rst_rpc", bus.redirect_pc, 0);
    check("rst_epc", bus.epc, 0);
    check("rst_cause", bus.cause, 0);
    check("rst_pend", bus.int_pending, 0);
    check("rst_tmo", bus.stall_timeout, 0);
    check("rst_pstall", bus.perf_stall_cyc, 0);
    check("rst_pflush", bus.perf_flush_cnt, 0);

    // thermometer stall, zero latency
    bus.stallreq = 6'b001000; #1;
    check("therm_3", bus.stall, 6'b001111);
    bus.stallreq = 6'b100001; #1;
    check("therm_5", bus.stall, 6'b111111);
    bus.stallreq = 6'b000001; #1;
    check("therm_0", bus.stall, 6'b000001);
    bus.stallreq = 6'b000000; #1;
    check("therm_none", bus.stall, 6'b000000);

    // exception with concurrent stallreq
    bus.stallreq   = 6'b000100;
    bus.excp_valid = 1'b1;
    bus.excp_code  = 5'd4;
    bus.excp_pc    = 32'hBFC00100;
    #1;
    check("exc_pre_stall", bus.stall, 6'b000111);
    tick();
    bus.excp_valid = 1'b0;
    #1;
    check("exc_flush", bus.flush, 1);
    check("exc_flush_stall", bus.stall, 0);
    check("exc_flush_rv", bus.redirect_valid, 0);
    check("exc_epc", bus.epc, 32'hBFC00100);
    check("exc_cause", bus.cause, 4);
    bus.stallreq = '0;
    tick();
    check("exc_rd_flush", bus.flush, 0);
    check("exc_rv", bus.redirect_valid, 1);
    check("exc_rpc", bus.redirect_pc, 32'hBFC00380);
    tick();
    check("exc_run_rv", bus.redirect_valid, 0);

    // eret returns to epc
    bus.eret_valid = 1'b1;
    tick();
    bus.eret_valid = 1'b0;
    check("eret_flush", bus.flush, 1);
    check("eret_epc", bus.epc, 32'hBFC00100);
    tick();
    check("eret_rv", bus.redirect_valid, 1);
    check("eret_rpc", bus.redirect_pc, 32'hBFC00100);
    tick();

    // excp beats eret; second excp during flush ignored
    bus.excp_valid = 1'b1;
    bus.excp_code  = 5'd8;
    bus.excp_pc    = 32'h80000010;
    bus.eret_valid = 1'b1;
    tick();
    bus.eret_valid = 1'b0;
    bus.excp_code  = 5'd12;
    bus.excp_pc    = 32'h80000020;
    #1;
    check("pri_flush", bus.flush, 1);
    check("pri_cause", bus.cause, 8);
    check("pri_epc", bus.epc, 32'h80000010);
    tick();
    bus.excp_valid = 1'b0;
    #1;
    check("pri_rpc", bus.redirect_pc, 32'hBFC00380);
    check("pri_cause2", bus.cause, 8);
    check("pri_epc2", bus.epc, 32'h80000010);
    tick();
    check("pri_run_flush", bus.flush, 0);

    // interrupt: sync, pend, take, ack
    bus.int_mask = 6'h04;
    bus.int_i    = 6'h04;
    tick();
    bus.int_i = '0;
    check("int_not_yet", bus.int_pending, 0);
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      tick();
      ok = bus.int_pending[2];
    end
    check("int_pend_set", ok, 1);
    tick();
    check("int_pend_hold", bus.int_pending, 6'h04);
    check("int_masked_off", bus.flush, 0);
    bus.excp_pc = 32'hBFC00200;
    bus.int_en  = 1'b1;
    tick();
    bus.int_en = 1'b0;
    check("int_flush", bus.flush, 1);
    check("int_cause", bus.cause, 0);
    check("int_epc", bus.epc, 32'hBFC00200);
    tick();
    check("int_rpc", bus.redirect_pc, 32'hBFC00380);
    bus.int_ack = 6'h04;
    tick();
    bus.int_ack = '0;
    check("int_ack_clr", bus.int_pending, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_flush", bus.perf_flush_cnt, 4);
`else
    check("perf_flush", bus.perf_flush_cnt, 0);
`endif

    // set and ack in same cycle: stays set
    bus.int_i = 6'h02;
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      tick();
      ok = bus.int_pending[1];
    end
    check("int1_set", ok, 1);
    bus.int_ack = 6'h02;
    tick();
    check("int1_setack", bus.int_pending, 6'h02);
    bus.int_i = '0;
    tick();
    tick();
    tick();
    bus.int_ack = '0;
    check("int1_clr", bus.int_pending, 0);

    // rst mid-sequence: no redirect
    bus.excp_valid = 1'b1;
    bus.excp_code  = 5'd10;
    tick();
    bus.excp_valid = 1'b0;
    check("mid_flush", bus.flush, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_flush", bus.flush, 0);
    check("mid_rst_rv", bus.redirect_valid, 0);
    check("mid_rst_epc", bus.epc, 0);
    tick();
    check("mid_no_rv", bus.redirect_valid, 0);

    // watchdog, TMO_W=4 -> trips after 15 stalled cycles
    bus.stallreq = 6'b000010;
    for (int i = 0; i < 14; i++) tick();
    check("wd_stall", bus.stall, 6'b000011);
    check("wd_14", bus.stall_timeout, 0);
    tick();
    check("wd_15", bus.stall_timeout, 1);
    bus.stallreq = '0;
    tick();
    check("wd_sticky", bus.stall_timeout, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_rst", bus.stall_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
